// File: rtl/io_fabric_pkg.sv
// Shared types and constants for the J1 I/O fabric: FSM state encoding,
// default read value, reserved status page and the default slave page table.
package io_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_RDATA_C = 16'h0666;
  localparam logic [7:0]  STATUS_PAGE     = 8'hFF;

  // Slot 0 sits in the low byte: slot0=0x67, slot1=0x68, slot2=0x69, slot3=0x70
  localparam logic [31:0] DEFAULT_PAGES_C = {8'h70, 8'h69, 8'h68, 8'h67};

endpackage

// File: rtl/io_page_decoder.sv
// Combinational page matcher: compares a page against every slot of the
// flattened page table; on duplicate pages the lowest slot index wins.
module io_page_decoder #(
  parameter int                            NUM_SLAVES  = 4,
  parameter int                            PAGE_W      = 8,
  parameter logic [NUM_SLAVES*PAGE_W-1:0]  SLAVE_PAGES = '0
) (
  input  logic [PAGE_W-1:0] page_i,
  output logic              hit_o,
  output logic [3:0]        idx_o
);

  // Scanning from the top down lets the lowest matching slot overwrite the rest
  always_comb begin
    hit_o = 1'b0;
    idx_o = 4'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (SLAVE_PAGES[i*PAGE_W +: PAGE_W] == page_i) begin
        hit_o = 1'b1;
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/j1_io_fabric.sv
// J1 I/O interconnect: page decode, one-hot select, ack/timeout sequencing and
// registered read return. Define IO_FABRIC_ERRLOG_EN for the 0xFF status page.
module j1_io_fabric
  import io_fabric_pkg::*;
#(
  parameter int                           NUM_SLAVES    = 4,
  parameter int                           DATA_W        = 16,
  parameter int                           ADDR_W        = 16,
  parameter int                           PAGE_W        = 8,
  parameter logic [NUM_SLAVES*PAGE_W-1:0] SLAVE_PAGES   = (NUM_SLAVES*PAGE_W)'(DEFAULT_PAGES_C),
  parameter int                           TIMEOUT       = 15,
  parameter logic [DATA_W-1:0]            DEFAULT_RDATA = DATA_W'(DEFAULT_RDATA_C)
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_i,
  input  logic                         io_rd,
  input  logic                         io_wr,
  input  logic [ADDR_W-1:0]            io_addr,
  input  logic [DATA_W-1:0]            io_dout,
  output logic [DATA_W-1:0]            io_din,
  output logic                         io_wait,
  output logic                         io_err,
  output logic [NUM_SLAVES-1:0]        per_cs,
  output logic                         per_rd,
  output logic                         per_wr,
  output logic [ADDR_W-PAGE_W-1:0]     per_addr,
  output logic [DATA_W-1:0]            per_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] per_rdata,
  input  logic [NUM_SLAVES-1:0]        per_ack
);

  localparam int          OFS_W   = ADDR_W - PAGE_W;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic [NUM_SLAVES-1:0]   per_cs_q;
  logic                    per_rd_q;
  logic                    per_wr_q;
  logic [OFS_W-1:0]        per_addr_q;
  logic [DATA_W-1:0]       per_wdata_q;
  logic [DATA_W-1:0]       io_din_q;
  logic                    io_wait_q;
  logic                    io_err_q;

  logic [PAGE_W-1:0]       page;
  logic                    decHit;
  logic [3:0]              decIdx;
  logic [NUM_SLAVES-1:0]   csOneHot;
  logic                    ackSel;
  logic [DATA_W-1:0]       rdataSel;
  logic                    statusHit;
  logic [DATA_W-1:0]       statusWord;

  assign page = io_addr[ADDR_W-1 -: PAGE_W];

  io_page_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .PAGE_W      (PAGE_W),
    .SLAVE_PAGES (SLAVE_PAGES)
  ) u_decoder (
    .page_i (page),
    .hit_o  (decHit),
    .idx_o  (decIdx)
  );

  // The held one-hot select doubles as the slot pointer for ack and read-data muxing
  always_comb begin
    csOneHot = '0;
    rdataSel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      csOneHot[i] = (decIdx == 4'(i));
      if (per_cs_q[i]) rdataSel = per_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ackSel = |(per_ack & per_cs_q);

`ifdef IO_FABRIC_ERRLOG_EN
  logic [7:0] errCount_q;
  logic [3:0] lastSlot_q;
  logic       lastTo_q;
  logic       lastUnm_q;
  logic       logUnm;
  logic       logTo;
  logic       logClr;
  logic [3:0] csIdx;

  assign statusHit  = (page == PAGE_W'(STATUS_PAGE));
  assign statusWord = DATA_W'({errCount_q, lastSlot_q, 2'b00, lastTo_q, lastUnm_q});
  assign logClr     = (state_q == ST_IDLE) && io_wr && statusHit;
  assign logUnm     = (state_q == ST_IDLE) && (io_rd || io_wr) && !statusHit && !decHit;
  assign logTo      = (state_q == ST_ACCESS) && !ackSel && (cnt_q == TO_LAST);

  always_comb begin
    csIdx = 4'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (per_cs_q[i]) csIdx = 4'(i);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || logClr) begin
      errCount_q <= 8'd0;
      lastSlot_q <= 4'd0;
      lastTo_q   <= 1'b0;
      lastUnm_q  <= 1'b0;
    end else if (logUnm || logTo) begin
      if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
      lastSlot_q <= logTo ? csIdx : 4'd0;
      lastTo_q   <= logTo;
      lastUnm_q  <= logUnm;
    end
  end
`else
  assign statusHit  = 1'b0;
  assign statusWord = DEFAULT_RDATA;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      per_cs_q    <= '0;
      per_rd_q    <= 1'b0;
      per_wr_q    <= 1'b0;
      per_addr_q  <= '0;
      per_wdata_q <= '0;
      io_din_q    <= DEFAULT_RDATA;
      io_wait_q   <= 1'b0;
      io_err_q    <= 1'b0;
    end else begin
      io_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (io_rd || io_wr) begin
            // Status register completes in one cycle and never reaches a slave
            if (statusHit) begin
              if (!io_wr) io_din_q <= statusWord;
              state_q <= ST_DONE;
            end else if (decHit) begin
              per_cs_q   <= csOneHot;
              per_rd_q   <= io_rd && !io_wr;
              per_wr_q   <= io_wr;
              per_addr_q <= io_addr[OFS_W-1:0];
              if (io_wr) per_wdata_q <= io_dout;
              io_wait_q  <= 1'b1;
              cnt_q      <= 8'd0;
              state_q    <= ST_ACCESS;
            end else begin
              io_wait_q <= 1'b1;
              io_err_q  <= 1'b1;
              if (!io_wr) io_din_q <= DEFAULT_RDATA;
              state_q   <= ST_ERR;
            end
          end
        end
        ST_ACCESS: begin
          if (ackSel) begin
            if (per_rd_q) io_din_q <= rdataSel;
            per_cs_q  <= '0;
            per_rd_q  <= 1'b0;
            per_wr_q  <= 1'b0;
            io_wait_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == TO_LAST) begin
            if (per_rd_q) io_din_q <= DEFAULT_RDATA;
            per_cs_q <= '0;
            per_rd_q <= 1'b0;
            per_wr_q <= 1'b0;
            io_err_q <= 1'b1;
            state_q  <= ST_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_ERR: begin
          io_wait_q <= 1'b0;
          state_q   <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_din    = io_din_q;
  assign io_wait   = io_wait_q;
  assign io_err    = io_err_q;
  assign per_cs    = per_cs_q;
  assign per_rd    = per_rd_q;
  assign per_wr    = per_wr_q;
  assign per_addr  = per_addr_q;
  assign per_wdata = per_wdata_q;

endmodule

// File: tb/tb_j1_io_fabric.sv
// Directed bench for j1_io_fabric with a wait-state slave model per slot.
// Status-page checks switch on IO_FABRIC_ERRLOG_EN.
module tb_j1_io_fabric;

  logic        clk;
  logic        sys_rst_i;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        io_wait;
  logic        io_err;
  logic [3:0]  per_cs;
  logic        per_rd;
  logic        per_wr;
  logic [7:0]  per_addr;
  logic [15:0] per_wdata;
  logic [63:0] per_rdata;
  logic [3:0]  per_ack;

  logic [7:0]  slvCnt [4];
  int          waitSt [4];
  logic [3:0]  modelAck;
  logic [3:0]  spurAck;

  int          errors;
  int          checks;

  int          obsLat;
  int          obsWaitHi;
  int          obsRd;
  int          obsWr;
  int          obsErr;
  logic [3:0]  obsCs;
  logic [7:0]  obsAddr;
  logic [15:0] obsWdata;

  j1_io_fabric dut (
    .sys_clk_i (clk),
    .sys_rst_i (sys_rst_i),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .io_wait   (io_wait),
    .io_err    (io_err),
    .per_cs    (per_cs),
    .per_rd    (per_rd),
    .per_wr    (per_wr),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_rdata (per_rdata),
    .per_ack   (per_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign per_rdata = {16'hCAFE, 16'h2222, 16'h1111, 16'hBEEF};

  // Each slave acks once it has been selected for waitSt cycles
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sys_rst_i || !per_cs[i]) slvCnt[i] <= 8'd0;
      else                         slvCnt[i] <= slvCnt[i] + 8'd1;
    end
  end

  always_comb begin
    modelAck = '0;
    for (int i = 0; i < 4; i++) begin
      modelAck[i] = per_cs[i] && (int'(slvCnt[i]) == waitSt[i]);
    end
  end

  assign per_ack = modelAck | spurAck;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one access from a negedge and watches it until io_wait falls
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] dout);
    io_rd     = rd;
    io_wr     = wr;
    io_addr   = addr;
    io_dout   = dout;
    obsLat    = 0;
    obsWaitHi = 0;
    obsRd     = 0;
    obsWr     = 0;
    obsErr    = 0;
    obsCs     = '0;
    obsAddr   = '0;
    obsWdata  = '0;
    do begin
      @(negedge clk);
      obsLat++;
      if (io_wait) obsWaitHi++;
      if (per_rd)  obsRd++;
      if (per_wr)  obsWr++;
      if (io_err)  obsErr++;
      obsCs = obsCs | per_cs;
      if (per_cs != 4'd0) begin
        obsAddr  = per_addr;
        obsWdata = per_wdata;
      end
    end while (io_wait && obsLat < 40);
    io_rd = 1'b0;
    io_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    sys_rst_i = 1'b1;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    io_addr   = '0;
    io_dout   = '0;
    spurAck   = '0;
    waitSt    = '{0, 3, 255, 1};
    repeat (2) @(negedge clk);

    checkOutput("rst_din",  io_din,  16'h0666);
    checkOutput("rst_wait", io_wait, 1'b0);
    checkOutput("rst_cs",   per_cs,  4'b0000);
    checkOutput("rst_strb", {per_rd, per_wr, io_err}, 3'b000);
    sys_rst_i = 1'b0;
    @(negedge clk);

    // Zero-wait read from slot0
    applyStimulus(1'b1, 1'b0, 16'h6703, 16'h0000);
    checkOutput("rd0_lat",  obsLat,  2);
    checkOutput("rd0_cs",   obsCs,   4'b0001);
    checkOutput("rd0_addr", obsAddr, 8'h03);
    checkOutput("rd0_din",  io_din,  16'hBEEF);
    checkOutput("rd0_err",  obsErr,  0);

    // Write with three wait states
    applyStimulus(1'b0, 1'b1, 16'h6810, 16'h1234);
    checkOutput("wr1_wr",    obsWr,     4);
    checkOutput("wr1_rd",    obsRd,     0);
    checkOutput("wr1_cs",    obsCs,     4'b0010);
    checkOutput("wr1_wdata", obsWdata,  16'h1234);
    checkOutput("wr1_waithi", obsWaitHi, 4);
    checkOutput("wr1_din",   io_din,    16'hBEEF);

    // One wait state read from slot3
    applyStimulus(1'b1, 1'b0, 16'h70AA, 16'h0000);
    checkOutput("rd3_lat", obsLat, 3);
    checkOutput("rd3_din", io_din, 16'hCAFE);

    // Unmapped read
    applyStimulus(1'b1, 1'b0, 16'h5500, 16'h0000);
    checkOutput("unm_cs",  obsCs,  4'b0000);
    checkOutput("unm_err", obsErr, 1);
    checkOutput("unm_din", io_din, 16'h0666);

    // Unmapped write leaves read data and slaves untouched
    applyStimulus(1'b1, 1'b0, 16'h6700, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h5512, 16'hAAAA);
    checkOutput("unmw_cs",  obsCs,  4'b0000);
    checkOutput("unmw_wr",  obsWr,  0);
    checkOutput("unmw_err", obsErr, 1);
    checkOutput("unmw_din", io_din, 16'hBEEF);

    // Slot2 never acks: 15 strobe cycles, then error
    applyStimulus(1'b1, 1'b0, 16'h6900, 16'h0000);
    checkOutput("to_rd",     obsRd,     15);
    checkOutput("to_err",    obsErr,    1);
    checkOutput("to_waithi", obsWaitHi, 16);
    checkOutput("to_din",    io_din,    16'h0666);

    // Ack arriving on the last allowed cycle is still an ack
    waitSt[2] = 14;
    applyStimulus(1'b1, 1'b0, 16'h6901, 16'h0000);
    checkOutput("edge_rd",  obsRd,  15);
    checkOutput("edge_err", obsErr, 0);
    checkOutput("edge_din", io_din, 16'h2222);
    waitSt[2] = 255;

    // Acks from non-selected slots are ignored
    waitSt[0] = 2;
    spurAck   = 4'b1010;
    applyStimulus(1'b1, 1'b0, 16'h6704, 16'h0000);
    checkOutput("spur_rd",  obsRd,  3);
    checkOutput("spur_din", io_din, 16'hBEEF);
    spurAck   = '0;
    waitSt[0] = 0;

    // Simultaneous rd+wr, then reset in the middle of the access
    waitSt[3] = 255;
    io_rd   = 1'b1;
    io_wr   = 1'b1;
    io_addr = 16'h7001;
    io_dout = 16'h5A5A;
    @(negedge clk);
    checkOutput("rw_strb",  {per_rd, per_wr}, 2'b01);
    checkOutput("rw_cs",    per_cs,    4'b1000);
    checkOutput("rw_wdata", per_wdata, 16'h5A5A);
    sys_rst_i = 1'b1;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    spurAck   = 4'b1000;
    @(negedge clk);
    checkOutput("rr_cs",   per_cs, 4'b0000);
    checkOutput("rr_strb", {per_rd, per_wr, io_wait, io_err}, 4'b0000);
    checkOutput("rr_addr", {per_addr, per_wdata}, 24'h000000);
    checkOutput("rr_din",  io_din, 16'h0666);
    sys_rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rr_late", {io_wait, per_cs, io_din}, {1'b0, 4'b0000, 16'h0666});
    spurAck   = '0;
    waitSt[3] = 1;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 16'h6700, 16'h0000);
`ifdef IO_FABRIC_ERRLOG_EN
    applyStimulus(1'b1, 1'b0, 16'h5500, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    checkOutput("st_din", io_din, 16'h0201);
    checkOutput("st_cs",  obsCs,  4'b0000);
    checkOutput("st_err", obsErr, 0);
    applyStimulus(1'b0, 1'b1, 16'hFF00, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    checkOutput("st_clr", io_din, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h6900, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    checkOutput("st_to", io_din, 16'h0122);
`else
    applyStimulus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    checkOutput("ff_err", obsErr, 1);
    checkOutput("ff_cs",  obsCs,  4'b0000);
    checkOutput("ff_din", io_din, 16'h0666);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
